spi_slave_rx: RTL and testbench

SPI slave (responder) for the FPGA SPI link: the receiving end of the on-chip SPI master. Oversamples SCK, CS_n and MOSI in the system clock domain, shifts in bytes MSB-first and presents each completed byte with a one-cycle valid pulse. Optionally returns a response byte on MISO, full-duplex, using the same SPI mode as the master.

---
 rtl/spi_slave_rx.sv | 247 ++++++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
//
// SPI responder for the on-chip SPI link. SCK, CS_n and MOSI are oversampled in the i_Clk
// domain through a synchronizer chain. Received bytes are shifted in MSB-first and presented
// with a one-cycle valid pulse. A response byte is returned on MISO, full-duplex, using the
// same SPI mode as the master.
//
// Parameters
//   SPI_MODE     SPI mode 0..3 (CPOL = bit 1, CPHA = bit 0); must match the master.
//   SYNC_STAGES  synchronizer depth for SCK/CS_n/MOSI, at least 2.
//
// Ports
//   i_Clk          system clock, all logic on its rising edge
//   i_Rst_L        asynchronous active-low reset
//   i_SPI_Clk      SCK from the master (asynchronous to i_Clk)
//   i_SPI_CS_n     chip select, active-low
//   i_SPI_MOSI     serial data from the master
//   o_SPI_MISO     serial data to the master
//   o_SPI_MISO_En  MISO output enable, high while the frame is active
//   o_RX_DV        one-cycle pulse, o_RX_Byte holds a new byte
//   o_RX_Byte      last completed byte, held until the next completion
//   i_TX_Byte      response byte
//   i_TX_DV        one-cycle pulse, writes i_TX_Byte into the holding register
//   o_TX_Ready     holding register empty
//   o_Frame_Err    one-cycle pulse, CS_n deasserted in the middle of a byte
module spi_slave_rx #(
    parameter int unsigned SPI_MODE    = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_Frame_Err
);

    localparam logic CPOL = (SPI_MODE & 32'd2) != 32'd0;
    localparam logic CPHA = (SPI_MODE & 32'd1) != 32'd0;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_n_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   cs_n_prev_q;

    logic sck_s;
    logic cs_n_s;
    logic mosi_s;

    // SCK resets to its idle level so reset release never fakes an edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sck_sync_q  <= {SYNC_STAGES{CPOL}};
            cs_n_sync_q <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            sck_prev_q  <= CPOL;
            cs_n_prev_q <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
            cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
            sck_prev_q  <= sck_s;
            cs_n_prev_q <= cs_n_s;
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync_q[SYNC_STAGES-1];
    // MOSI travels through the same depth as SCK, so it lines up with the detected edge.
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic cs_fall;
    logic cs_rise;

    assign lead_edge   = (sck_prev_q == CPOL) && (sck_s != CPOL);
    assign trail_edge  = (sck_prev_q != CPOL) && (sck_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_n_prev_q && !cs_n_s;
    assign cs_rise     = !cs_n_prev_q && cs_n_s;

    // ------------------------------------------------------------------
    // Frame state, shift registers and holding register
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    // Only the first seven bits of a byte are stored; the eighth is taken straight from MOSI
    // when the byte completes.
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic       frame_err_q, frame_err_d;
    logic       miso_q, miso_d;
    // Set when the next shift edge must present tx_shift_q[7] rather than advance the
    // register: after a reload, and for CPHA=1 at the start of a frame.
    logic       msb_next_q, msb_next_d;
    logic [7:0] hold_byte_q, hold_byte_d;
    logic       hold_full_q, hold_full_d;

    logic [7:0] rx_word;
    logic [7:0] load_byte;
    logic       reload;

    assign rx_word = {rx_shift_q, mosi_s};

    // A write in the same cycle as a reload bypasses the holding register.
    assign load_byte = i_TX_DV     ? i_TX_Byte   :
                       hold_full_q ? hold_byte_q : 8'h00;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;
        msb_next_d  = msb_next_q;
        hold_byte_d = hold_byte_q;
        hold_full_d = hold_full_q;
        reload      = 1'b0;

        if (i_TX_DV) begin
            hold_byte_d = i_TX_Byte;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                bit_cnt_d  = 3'd7;
                rx_shift_d = '0;
                msb_next_d = 1'b0;
                if (cs_fall) begin
                    state_d    = StActive;
                    reload     = 1'b1;
                    msb_next_d = CPHA;
                    // CPHA=0: the master samples before any SCK edge, so the MSB goes out now.
                    if (!CPHA) begin
                        miso_d = load_byte[7];
                    end
                end
            end

            StActive: begin
                if (cs_rise) begin
                    state_d    = StIdle;
                    bit_cnt_d  = 3'd7;
                    rx_shift_d = '0;
                    msb_next_d = 1'b0;
                    miso_d     = 1'b0;
                    if (bit_cnt_q != 3'd7) begin
                        frame_err_d = 1'b1;
                    end
                end else if (sample_edge) begin
                    rx_shift_d = rx_word[6:0];
                    if (bit_cnt_q == 3'd0) begin
                        rx_byte_d  = rx_word;
                        rx_dv_d    = 1'b1;
                        bit_cnt_d  = 3'd7;
                        reload     = 1'b1;
                        msb_next_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end else if (shift_edge) begin
                    if (msb_next_q) begin
                        miso_d     = tx_shift_q[7];
                        msb_next_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (reload) begin
            tx_shift_d  = load_byte;
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd7;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            msb_next_q  <= 1'b0;
            hold_byte_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            msb_next_q  <= msb_next_d;
            hold_byte_q <= hold_byte_d;
            hold_full_q <= hold_full_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_SPI_MISO    = miso_q;
    assign o_SPI_MISO_En = (state_q == StActive);
    assign o_RX_DV       = rx_dv_q;
    assign o_RX_Byte     = rx_byte_q;
    assign o_TX_Ready    = !hold_full_q;
    assign o_Frame_Err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx
//
// Bench for spi_slave_rx. One responder per SPI mode (0..3) shares reset, MOSI and TX data;
// each has its own SCK, CS_n and TX_DV, and only one frame runs at a time. A master model
// drives frames and captures MISO at its own sampling edges; a monitor logs every RX_DV and
// Frame_Err pulse. Expected results come from a table of directed vectors and from a
// frame-level reference model for randomized frames.
module tb_spi_slave_rx;

    logic       clk;
    logic       rst_l;
    logic [3:0] sck;
    logic [3:0] cs_n;
    logic [3:0] tx_dv;
    logic       mosi;
    logic [7:0] tx_byte;
    logic [3:0] miso;
    logic [3:0] miso_en;
    logic [3:0] rx_dv;
    logic [3:0] tx_ready;
    logic [3:0] ferr;
    logic [7:0] rx_byte [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_rx #(
            .SPI_MODE    (g),
            .SYNC_STAGES (2)
        ) u_dut (
            .i_Clk         (clk),
            .i_Rst_L       (rst_l),
            .i_SPI_Clk     (sck[g]),
            .i_SPI_CS_n    (cs_n[g]),
            .i_SPI_MOSI    (mosi),
            .o_SPI_MISO    (miso[g]),
            .o_SPI_MISO_En (miso_en[g]),
            .o_RX_DV       (rx_dv[g]),
            .o_RX_Byte     (rx_byte[g]),
            .i_TX_Byte     (tx_byte),
            .i_TX_DV       (tx_dv[g]),
            .o_TX_Ready    (tx_ready[g]),
            .o_Frame_Err   (ferr[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Monitor: every RX_DV / Frame_Err pulse, sampled on falling edges
    // ---------------------------------------------------------------
    typedef struct {
        int         dut;
        logic [7:0] b;
    } rx_ev_t;

    rx_ev_t rx_log[$];
    int     ferr_cnt [4];

    initial begin
        rx_ev_t ev;
        for (int k = 0; k < 4; k++) ferr_cnt[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (rx_dv[k] === 1'b1) begin
                    ev.dut = k;
                    ev.b   = rx_byte[k];
                    rx_log.push_back(ev);
                end
                if (ferr[k] === 1'b1) ferr_cnt[k]++;
            end
        end
    end

    function automatic int ferr_total();
        int s = 0;
        for (int k = 0; k < 4; k++) s += ferr_cnt[k];
        return s;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Master model
    // ---------------------------------------------------------------
    logic [7:0] f_data [0:3];
    logic [7:0] f_cap  [0:3];
    logic       en_seen;

    // Expected results for the frame under test.
    int         e_nrx;
    int         e_ferr;
    logic [7:0] e_rx   [0:3];
    logic [7:0] e_miso [0:3];

    task automatic pulse_tx(input int m, input logic [7:0] b);
        tx_byte  = b;
        tx_dv[m] = 1'b1;
        @(negedge clk);
        tx_dv[m] = 1'b0;
    endtask

    task automatic xfer(input int m, input int nbits, input int h, input bit raise_cs,
                        input bit mid_wr, input logic [7:0] mid_b);
        logic cpol;
        logic cpha;
        int   bi;
        int   bb;
        cpol = m[1];
        cpha = m[0];
        cs_n[m] = 1'b0;
        repeat (2 * h) @(negedge clk);
        en_seen = miso_en[m];
        for (int i = 0; i < nbits; i++) begin
            bi = i / 8;
            bb = 7 - (i % 8);
            if (mid_wr && i == 2) pulse_tx(m, mid_b);
            if (!cpha) begin
                mosi = f_data[bi][bb];
                repeat (h) @(negedge clk);
                f_cap[bi][bb] = miso[m];
                sck[m] = ~cpol;
                repeat (h) @(negedge clk);
                sck[m] = cpol;
            end else begin
                sck[m] = ~cpol;
                mosi   = f_data[bi][bb];
                repeat (h) @(negedge clk);
                f_cap[bi][bb] = miso[m];
                sck[m] = cpol;
                repeat (h) @(negedge clk);
            end
        end
        repeat (2 * h) @(negedge clk);
        if (raise_cs) begin
            cs_n[m] = 1'b1;
            repeat (2 * h) @(negedge clk);
        end
    endtask

    // Runs one complete frame and compares everything against e_* / expectations.
    task automatic run_frame(input string tag, input int m, input int nbytes, input int pbits,
                             input int npre, input logic [7:0] pre0, input logic [7:0] pre1,
                             input bit mid_wr, input logic [7:0] mid_b, input int h);
        int fe0;
        rx_log.delete();
        fe0 = ferr_total();
        if (npre > 0) begin
            chk({tag, " ready_before"}, 32'(tx_ready[m]), 1);
            pulse_tx(m, pre0);
            if (npre > 1) pulse_tx(m, pre1);
            chk({tag, " ready_low"}, 32'(tx_ready[m]), 0);
        end
        xfer(m, nbytes * 8 + pbits, h, 1'b1, mid_wr, mid_b);
        repeat (4) @(negedge clk);
        chk({tag, " rx_count"}, rx_log.size(), e_nrx);
        for (int j = 0; j < rx_log.size() && j < e_nrx; j++) begin
            chk({tag, " rx_dut"}, rx_log[j].dut, m);
            chk({tag, " rx_byte"}, 32'(rx_log[j].b), 32'(e_rx[j]));
        end
        chk({tag, " frame_err"}, ferr_total() - fe0, e_ferr);
        for (int j = 0; j < nbytes; j++) begin
            chk({tag, " miso_byte"}, 32'(f_cap[j]), 32'(e_miso[j]));
        end
        chk({tag, " en_active"}, 32'(en_seen), 1);
        chk({tag, " en_idle"}, 32'(miso_en[m]), 0);
        chk({tag, " ready_after"}, 32'(tx_ready[m]), 1);
    endtask

    // ---------------------------------------------------------------
    // Directed vectors
    // ---------------------------------------------------------------
    typedef struct {
        int         mode;
        int         nbytes;
        int         pbits;
        int         npre;
        logic [7:0] pre0;
        logic [7:0] pre1;
        logic [7:0] d0;
        logic [7:0] d1;
        int         exp_nrx;
        logic [7:0] exp_rx0;
        logic [7:0] exp_rx1;
        int         exp_ferr;
        logic [7:0] exp_miso0;
        logic [7:0] exp_miso1;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int         fe0;
        int         en_hits;
        int         m;
        int         nbytes;
        int         pbits;
        int         npre;
        int         h;
        bit         mid_wr;
        logic [7:0] pre0;
        logic [7:0] pre1;
        logic [7:0] mid_b;

        vecs[0] = '{3, 1, 0, 0, 8'h00, 8'h00, 8'h92, 8'h00, 1, 8'h92, 8'h00, 0, 8'h00, 8'h00};
        vecs[1] = '{0, 2, 0, 0, 8'h00, 8'h00, 8'hA5, 8'h3C, 2, 8'hA5, 8'h3C, 0, 8'h00, 8'h00};
        vecs[2] = '{1, 2, 0, 0, 8'h00, 8'h00, 8'hA5, 8'h3C, 2, 8'hA5, 8'h3C, 0, 8'h00, 8'h00};
        vecs[3] = '{2, 2, 0, 0, 8'h00, 8'h00, 8'hA5, 8'h3C, 2, 8'hA5, 8'h3C, 0, 8'h00, 8'h00};
        vecs[4] = '{3, 2, 0, 1, 8'hC3, 8'h00, 8'h00, 8'h00, 2, 8'h00, 8'h00, 0, 8'hC3, 8'h00};
        vecs[5] = '{0, 2, 0, 1, 8'hC3, 8'h00, 8'h00, 8'h00, 2, 8'h00, 8'h00, 0, 8'hC3, 8'h00};
        vecs[6] = '{3, 0, 5, 0, 8'h00, 8'h00, 8'hB6, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00};
        vecs[7] = '{3, 1, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h00, 1, 8'h5A, 8'h00, 0, 8'h00, 8'h00};
        vecs[8] = '{1, 1, 0, 2, 8'h11, 8'h77, 8'h0F, 8'h00, 1, 8'h0F, 8'h00, 0, 8'h77, 8'h00};

        sck     = 4'b1100;
        cs_n    = 4'hF;
        tx_dv   = 4'h0;
        mosi    = 1'b0;
        tx_byte = 8'h00;
        rst_l   = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset miso", 32'(miso[k]), 0);
            chk("reset miso_en", 32'(miso_en[k]), 0);
            chk("reset rx_dv", 32'(rx_dv[k]), 0);
            chk("reset rx_byte", 32'(rx_byte[k]), 0);
            chk("reset tx_ready", 32'(tx_ready[k]), 1);
            chk("reset frame_err", 32'(ferr[k]), 0);
        end
        rst_l = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            f_data[0] = vecs[v].d0;
            f_data[1] = vecs[v].d1;
            e_nrx     = vecs[v].exp_nrx;
            e_rx[0]   = vecs[v].exp_rx0;
            e_rx[1]   = vecs[v].exp_rx1;
            e_ferr    = vecs[v].exp_ferr;
            e_miso[0] = vecs[v].exp_miso0;
            e_miso[1] = vecs[v].exp_miso1;
            run_frame($sformatf("vec%0d", v), vecs[v].mode, vecs[v].nbytes, vecs[v].pbits,
                      vecs[v].npre, vecs[v].pre0, vecs[v].pre1, 1'b0, 8'h00, 4);
        end

        // SCK activity with CS_n high must be ignored.
        rx_log.delete();
        fe0     = ferr_total();
        en_hits = 0;
        for (int i = 0; i < 16; i++) begin
            sck[2] = ~sck[2];
            mosi   = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            if (miso_en[2] !== 1'b0) en_hits++;
        end
        chk("cs_high rx_count", rx_log.size(), 0);
        chk("cs_high en_hits", en_hits, 0);
        chk("cs_high frame_err", ferr_total() - fe0, 0);

        // Randomized frames against the frame-level reference model.
        for (int n = 0; n < 40; n++) begin
            m      = $urandom_range(0, 3);
            nbytes = $urandom_range(1, 3);
            pbits  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            npre   = $urandom_range(0, 2);
            pre0   = 8'($urandom);
            pre1   = 8'($urandom);
            mid_wr = (nbytes >= 2) && ($urandom_range(0, 1) == 1);
            mid_b  = 8'($urandom);
            h      = $urandom_range(4, 6);
            for (int j = 0; j < 4; j++) begin
                f_data[j] = 8'($urandom);
                e_rx[j]   = f_data[j];
                e_miso[j] = 8'h00;
            end
            e_nrx  = nbytes;
            e_ferr = (pbits != 0) ? 1 : 0;
            // The latest write before CS falls answers the first byte; a write during the
            // first byte answers the second; everything else answers 0.
            if (npre == 1) e_miso[0] = pre0;
            if (npre == 2) e_miso[0] = pre1;
            if (mid_wr) e_miso[1] = mid_b;
            run_frame($sformatf("rnd%0d", n), m, nbytes, pbits, npre, pre0, pre1,
                      mid_wr, mid_b, h);
        end

        // Reset in the middle of a byte, with the holding register full.
        f_data[0] = 8'h6D;
        xfer(3, 3, 4, 1'b0, 1'b0, 8'h00);
        pulse_tx(3, 8'hE7);
        chk("pre_reset ready_low", 32'(tx_ready[3]), 0);
        chk("pre_reset en", 32'(miso_en[3]), 1);
        rst_l = 1'b0;
        @(negedge clk);
        chk("mid_reset miso", 32'(miso[3]), 0);
        chk("mid_reset miso_en", 32'(miso_en[3]), 0);
        chk("mid_reset rx_dv", 32'(rx_dv[3]), 0);
        chk("mid_reset rx_byte", 32'(rx_byte[3]), 0);
        chk("mid_reset tx_ready", 32'(tx_ready[3]), 1);
        chk("mid_reset frame_err", 32'(ferr[3]), 0);
        cs_n[3] = 1'b1;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (8) @(negedge clk);
        f_data[0] = 8'hFF;
        e_nrx     = 1;
        e_rx[0]   = 8'hFF;
        e_ferr    = 0;
        e_miso[0] = 8'h00;
        run_frame("post_reset", 3, 1, 0, 0, 8'h00, 8'h00, 1'b0, 8'h00, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
